// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic {RUN, MD_BUSY} ctrl_state_t;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
  localparam int MD_CNT_W = 4;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load in EX
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  output logic                  load_use
);
  assign load_use = idex_memread && idex_rt != ZERO_REG &&
                    (idex_rt == id_rs || (id_uses_rt && idex_rt == id_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use, mispredict and mul/div sequencing for the 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic                  ex_mispredict,
  input  logic                  ex_muldiv_start,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  ex_hold,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);
  ctrl_state_t         state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]    stall_q, flush_q;
  logic                load_use, run, mis, md_start, md_hold, lu_stall, stall;

  load_use_detect u_lud (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .load_use     (load_use)
  );

  // Load-use applies in RUN and in the MD_BUSY release cycle, below mispredict and mul/div start
  always_comb begin
    run        = state_q == RUN;
    mis        = run && ex_mispredict;
    md_start   = run && !ex_mispredict && ex_muldiv_start;
    md_hold    = !run && md_cnt_q != '0;
    lu_stall   = load_use && !mis && !md_start && !md_hold;
    stall      = md_start || md_hold || lu_stall;
    pc_write   = !rst && !stall;
    ifid_write = !rst && !stall;
    ifid_flush = !rst && mis;
    idex_flush = !rst && (mis || lu_stall);
    ex_hold    = !rst && (md_start || md_hold);
    md_cnt_d   = md_start ? MD_CNT_W'(MULDIV_LAT - 2) : md_hold ? md_cnt_q - 1'b1 : md_cnt_q;
    state_d    = md_start ? MD_BUSY : (!run && !md_hold) ? RUN : state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      if (stall && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (mis && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign busy         = state_q == MD_BUSY;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of hazard controls, mul/div timing, reset and counter saturation
module tb_pipe_hazard_ctrl;
  logic       clk = 0, rst = 1;
  logic [4:0] a_rs = 0, a_rt = 0, a_xrt = 0, b_rs = 0, b_rt = 0, b_xrt = 0;
  logic       a_urt = 0, a_mr = 0, a_mis = 0, a_md = 0, b_urt = 0, b_mr = 0, b_mis = 0, b_md = 0;
  logic       a_pc, a_ifw, a_iff, a_idf, a_hold, a_busy, b_pc, b_ifw, b_iff, b_idf, b_hold, b_busy;
  logic [15:0] a_stall, a_flush;
  logic [3:0]  b_stall, b_flush;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs(a_rs), .id_rt(a_rt), .id_uses_rt(a_urt),
    .idex_memread(a_mr), .idex_rt(a_xrt), .ex_mispredict(a_mis), .ex_muldiv_start(a_md),
    .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_iff), .idex_flush(a_idf),
    .ex_hold(a_hold), .busy(a_busy), .stall_cycles(a_stall), .flush_count(a_flush));

  pipe_hazard_ctrl #(.MULDIV_LAT(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(b_rs), .id_rt(b_rt), .id_uses_rt(b_urt),
    .idex_memread(b_mr), .idex_rt(b_xrt), .ex_mispredict(b_mis), .ex_muldiv_start(b_md),
    .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_iff), .idex_flush(b_idf),
    .ex_hold(b_hold), .busy(b_busy), .stall_cycles(b_stall), .flush_count(b_flush));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks {pc_write, ifid_write, ifid_flush, idex_flush, ex_hold} of dut_a as one vector
  task automatic chk_a(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, a_pc, a_ifw, a_iff, a_idf, a_hold}, {27'd0, exp});
  endtask

  task automatic chk_b(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, b_pc, b_ifw, b_iff, b_idf, b_hold}, {27'd0, exp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk_a("rst_outs", 5'b00000);
    chk("rst_busy", {31'd0, a_busy}, 0);
    chk("rst_stall", {16'd0, a_stall}, 0);
    tick; tick;
    rst = 0;
    #1;
    chk_a("run_idle", 5'b11000);
    // load-use on rs
    a_mr = 1; a_xrt = 8; a_rs = 8;
    #1 chk_a("lu_rs", 5'b00010);
    tick;
    a_mr = 0; a_xrt = 0; a_rs = 0;
    #1 chk_a("lu_after", 5'b11000);
    chk("lu_stall_cnt", {16'd0, a_stall}, 1);
    // zero register never hazards
    a_mr = 1; a_xrt = 0; a_rs = 0;
    #1 chk_a("zero_reg", 5'b11000);
    // rt only compared when used
    a_xrt = 9; a_rt = 9; a_rs = 1; a_urt = 0;
    #1 chk_a("rt_unused", 5'b11000);
    a_urt = 1;
    #1 chk_a("rt_used", 5'b00010);
    tick;
    chk("rt_stall_cnt", {16'd0, a_stall}, 2);
    // mispredict outranks load-use and mul/div start
    a_xrt = 8; a_rs = 8; a_urt = 0; a_rt = 0; a_mis = 1; a_md = 1;
    #1 chk_a("mis_lu", 5'b11110);
    tick;
    a_mis = 0; a_md = 0; a_mr = 0; a_xrt = 0; a_rs = 0;
    #1 chk("mis_flush_cnt", {16'd0, a_flush}, 1);
    chk("mis_stall_cnt", {16'd0, a_stall}, 2);
    chk("mis_busy", {31'd0, a_busy}, 0);
    // mul/div, latency 4: three hold cycles then release
    a_md = 1;
    #1 chk_a("md_c1", 5'b00001);
    chk("md_c1_busy", {31'd0, a_busy}, 0);
    tick;
    a_md = 0; a_mis = 1;
    #1 chk_a("md_c2", 5'b00001);
    chk("md_c2_busy", {31'd0, a_busy}, 1);
    tick;
    a_mis = 0;
    #1 chk_a("md_c3", 5'b00001);
    chk("md_c3_busy", {31'd0, a_busy}, 1);
    tick;
    chk_a("md_c4", 5'b11000);
    tick;
    chk_a("md_after", 5'b11000);
    chk("md_after_busy", {31'd0, a_busy}, 0);
    chk("md_stall_cnt", {16'd0, a_stall}, 5);
    chk("md_flush_cnt", {16'd0, a_flush}, 1);
    // reset during the second MD_BUSY cycle
    a_md = 1;
    tick;
    a_md = 0;
    tick;
    #1 chk_a("md2_c3", 5'b00001);
    rst = 1;
    #1 chk_a("mdrst_outs", 5'b00000);
    chk("mdrst_busy", {31'd0, a_busy}, 0);
    chk("mdrst_stall", {16'd0, a_stall}, 0);
    chk("mdrst_flush", {16'd0, a_flush}, 0);
    tick;
    rst = 0;
    #1 chk_a("post_rst", 5'b11000);
    chk("post_rst_busy", {31'd0, a_busy}, 0);
    tick;
    chk_a("post_rst2", 5'b11000);
    chk("post_rst_stall", {16'd0, a_stall}, 0);
    // dut_b, latency 2: single hold cycle
    b_md = 1;
    #1 chk_b("b_md_c1", 5'b00001);
    tick;
    b_md = 0;
    #1 chk_b("b_md_c2", 5'b11000);
    tick;
    chk_b("b_md_c3", 5'b11000);
    chk("b_md_busy", {31'd0, b_busy}, 0);
    chk("b_md_stall", {28'd0, b_stall}, 1);
    // load-use is ignored under mul/div start but stalls in the release cycle
    b_md = 1; b_mr = 1; b_xrt = 3; b_rt = 3; b_urt = 1;
    #1 chk_b("b_mdlu_c1", 5'b00001);
    tick;
    b_md = 0;
    #1 chk_b("b_mdlu_rel", 5'b00010);
    tick;
    chk("b_mdlu_stall", {28'd0, b_stall}, 3);
    // saturation: keep the load-use hazard for 2^4+5 cycles
    for (int i = 0; i < 21; i++) tick;
    chk("b_stall_sat", {28'd0, b_stall}, 15);
    b_mr = 0;
    b_mis = 1;
    for (int i = 0; i < 21; i++) tick;
    chk("b_flush_sat", {28'd0, b_flush}, 15);
    chk("b_stall_hold", {28'd0, b_stall}, 15);
    b_mis = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
